slurm16_flash_dma: RTL and testbench
====================================

// Module: slurm16_flash_dma
// PURPOSE
//  Sequences the memory arbiter's flash write port. Takes a 16-bit word stream from the SPI flash
//  reader, buffers it in a small FIFO and issues auto-incrementing writes into the banked memory.
//  Sits between the flash reader and slurm16_memory_arbiter; the CPU-side register file configures it.
// PARAMETERS
//  FIFO_DEPTH  4  words of buffering between the source stream and the arbiter port (power of 2, >=2)
// PORTS
//  CLK                in   1   system clock
//  RSTb               in   1   asynchronous, active-low reset
//  dma_start          in   1   one-cycle pulse: begin transfer (ignored while busy)
//  dma_abort          in   1   one-cycle pulse: terminate running transfer
//  dma_base_addr      in   16  first destination word address, sampled on dma_start
//  dma_count          in   16  number of words to move, sampled on dma_start
//  src_data           in   16  word from flash reader
//  src_valid          in   1   src_data valid
//  src_ready          out  1   block accepts src_data this cycle
//  fl_memory_address  out  16  write address to arbiter
//  fl_memory_data     out  16  write data to arbiter
//  fl_wvalid          out  1   write request to arbiter
//  fl_wready          in   1   arbiter accepted write this cycle
//  busy               out  1   transfer in progress
//  done               out  1   one-cycle pulse at end of transfer (normal or aborted)
//  aborted            out  1   set with done if the transfer ended by abort; held until next dma_start
// BEHAVIOUR
//  Reset: state IDLE, FIFO empty, all outputs 0 (src_ready=0, fl_wvalid=0, address/data=0, busy=0,
//   done=0, aborted=0). Reset mid-transfer discards everything; no write completes after RSTb falls.
//  Handshakes: src transfer when src_valid&&src_ready. Arbiter write completes when fl_wvalid&&fl_wready.
//   Once fl_wvalid is high, fl_wvalid/address/data stay stable until the write completes (also during abort).
//  FSM:
//   IDLE : dma_start && dma_count!=0 -> RUN. Load addr=dma_base_addr, accept_cnt=wr_cnt=dma_count,
//          clear aborted. dma_start && dma_count==0 -> DONE (no writes).
//   RUN  : src_ready = (accept_cnt!=0) && FIFO not full. Each accepted word decrements accept_cnt.
//          Output register loads from FIFO head when empty or completing. Each completed write
//          decrements wr_cnt and increments addr. wr_cnt reaches 0 -> DONE. dma_abort -> FLUSH.
//   FLUSH: src_ready=0. Any pending fl_wvalid is held until accepted. FIFO is then cleared -> DONE with aborted=1.
//   DONE : done=1 for exactly one cycle, busy=0 -> IDLE.
//  busy=1 in RUN and FLUSH. dma_start in RUN/FLUSH/DONE is ignored. dma_abort outside RUN is ignored.
//  Latency: a word accepted in cycle N with an empty FIFO/output drives fl_wvalid in cycle N+1.
//   Sustained throughput is 1 word/cycle when fl_wready is held high. FIFO full and src_valid=1: src_ready=0.
//  Arithmetic: addr increments mod 2^16 (0xFFFF -> 0x0000). Counters are 16 bit.
//   Words beyond dma_count are never accepted (src_ready=0).
//  Simultaneous events: a write that completes in the cycle dma_abort arrives counts as done.
//   A completion that brings wr_cnt to 0 in the same cycle as abort -> DONE with aborted=0.
// TESTING
//  1. base=0x4000, count=3, src words 0x1111/0x2222/0x3333, fl_wready=1 -> writes 0x4000..0x4002
//     in consecutive cycles; done pulses 1 cycle after the last write; busy falls; aborted=0.
//  2. count=6, fl_wready held 0 -> src_ready drops after FIFO_DEPTH+1 words.
//     Release fl_wready -> all 6 writes in order, no loss or duplication.
//  3. base=0xFFFE, count=4 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
//  4. count=8, abort after 2 writes with fl_wvalid pending and fl_wready=0 -> address/data stay stable
//     until fl_wready; exactly 3 writes total; done=1 with aborted=1; src_ready=0 after abort.
//  5. dma_start with count=0 -> done pulses, no fl_wvalid. dma_start while busy -> ignored (count unchanged).
//  6. RSTb low mid-transfer -> all outputs 0 immediately. A new start after reset runs a clean transfer.

Source files
------------

// File: rtl/slurm16_flash_dma.sv
// Flash-to-memory DMA: buffers a 16-bit source stream in a small FIFO and issues
// auto-incrementing writes on the memory arbiter's flash write port.
module slurm16_flash_dma #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RSTb,
    input  logic        dma_start,
    input  logic        dma_abort,
    input  logic [15:0] dma_base_addr,
    input  logic [15:0] dma_count,
    input  logic [15:0] src_data,
    input  logic        src_valid,
    output logic        src_ready,
    output logic [15:0] fl_memory_address,
    output logic [15:0] fl_memory_data,
    output logic        fl_wvalid,
    input  logic        fl_wready,
    output logic        busy,
    output logic        done,
    output logic        aborted
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_r;
    logic [15:0]     addr_r;
    logic [15:0]     accept_cnt_r;
    logic [15:0]     wr_cnt_r;
    logic [15:0]     data_r;
    logic            wvalid_r;
    logic            busy_r;
    logic            done_r;
    logic            aborted_r;
    logic [15:0]     fifo_mem_r [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [CW-1:0]   fifo_cnt_r;

    logic            src_ready_s;
    logic            src_fire_s;
    logic            wr_done_s;
    logic            last_wr_s;
    logic            load_s;
    logic            bypass_s;
    logic            push_s;
    logic            pop_s;
    logic            flush_end_s;

    // Handshake decode and output-register load selection
    always_comb begin
        src_ready_s = (state_r == RUN) && (accept_cnt_r != 16'd0) && (fifo_cnt_r != FULL_CNT);
        src_fire_s  = src_valid && src_ready_s;
        wr_done_s   = wvalid_r && fl_wready;
        last_wr_s   = wr_done_s && (wr_cnt_r == 16'd1);
        flush_end_s = (state_r == FLUSH) && (!wvalid_r || wr_done_s);
        // An abort freezes the output register so no new write is started
        if ((state_r == RUN) && !dma_abort && !last_wr_s && (!wvalid_r || wr_done_s)
            && ((fifo_cnt_r != {CW{1'b0}}) || src_fire_s)) begin
            load_s = 1'b1;
        end else begin
            load_s = 1'b0;
        end
        bypass_s = load_s && (fifo_cnt_r == {CW{1'b0}});
        pop_s    = load_s && !bypass_s;
        push_s   = src_fire_s && !bypass_s;
    end

    // Source FIFO storage, pointers and occupancy
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= 16'h0000;
            end
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            fifo_cnt_r <= {CW{1'b0}};
        end else if (flush_end_s) begin
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            fifo_cnt_r <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= src_data;
                wr_ptr_r             <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + CW'(1);
                2'b01:   fifo_cnt_r <= fifo_cnt_r - CW'(1);
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    // Transfer sequencer with registered arbiter-side outputs
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state_r      <= IDLE;
            addr_r       <= 16'h0000;
            accept_cnt_r <= 16'h0000;
            wr_cnt_r     <= 16'h0000;
            data_r       <= 16'h0000;
            wvalid_r     <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            aborted_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (dma_start) begin
                        aborted_r <= 1'b0;
                        addr_r    <= dma_base_addr;
                        if (dma_count != 16'd0) begin
                            accept_cnt_r <= dma_count;
                            wr_cnt_r     <= dma_count;
                            busy_r       <= 1'b1;
                            state_r      <= RUN;
                        end else begin
                            done_r  <= 1'b1;
                            state_r <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (src_fire_s) begin
                        accept_cnt_r <= accept_cnt_r - 16'd1;
                    end
                    if (wr_done_s) begin
                        wr_cnt_r <= wr_cnt_r - 16'd1;
                        addr_r   <= addr_r + 16'd1;
                    end
                    if (load_s) begin
                        wvalid_r <= 1'b1;
                        data_r   <= bypass_s ? src_data : fifo_mem_r[rd_ptr_r];
                    end else if (wr_done_s) begin
                        wvalid_r <= 1'b0;
                    end
                    // Final completion wins over a simultaneous abort
                    if (last_wr_s) begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else if (dma_abort) begin
                        state_r <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (wr_done_s) begin
                        wr_cnt_r <= wr_cnt_r - 16'd1;
                        addr_r   <= addr_r + 16'd1;
                    end
                    if (flush_end_s) begin
                        wvalid_r  <= 1'b0;
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                        aborted_r <= 1'b1;
                        state_r   <= DONE;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign src_ready         = src_ready_s;
    assign fl_memory_address = addr_r;
    assign fl_memory_data    = data_r;
    assign fl_wvalid         = wvalid_r;
    assign busy              = busy_r;
    assign done              = done_r;
    assign aborted           = aborted_r;
endmodule

// File: tb/tb_slurm16_flash_dma.sv
// Directed bench for slurm16_flash_dma: one task per scenario, inline comparisons.
module tb_slurm16_flash_dma;
    logic        CLK = 1'b0;
    logic        RSTb = 1'b0;
    logic        dma_start = 1'b0;
    logic        dma_abort = 1'b0;
    logic [15:0] dma_base_addr = 16'h0000;
    logic [15:0] dma_count = 16'h0000;
    logic [15:0] src_data = 16'h0000;
    logic        src_valid = 1'b0;
    logic        src_ready;
    logic [15:0] fl_memory_address;
    logic [15:0] fl_memory_data;
    logic        fl_wvalid;
    logic        fl_wready = 1'b0;
    logic        busy;
    logic        done;
    logic        aborted;

    slurm16_flash_dma #(.FIFO_DEPTH(4)) dut (
        .CLK(CLK), .RSTb(RSTb), .dma_start(dma_start), .dma_abort(dma_abort),
        .dma_base_addr(dma_base_addr), .dma_count(dma_count),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .fl_memory_address(fl_memory_address), .fl_memory_data(fl_memory_data),
        .fl_wvalid(fl_wvalid), .fl_wready(fl_wready),
        .busy(busy), .done(done), .aborted(aborted)
    );

    always #5 CLK = ~CLK;

    int          passed = 0;
    int          total = 0;
    int          cyc = 0;
    logic [15:0] src_words [16];
    int          src_n = 0;
    int          src_idx = 0;
    bit          feed_en = 1'b0;
    logic [15:0] wa [32];
    logic [15:0] wd [32];
    int          wc [32];
    int          wn = 0;
    int          done_n = 0;
    int          done_cyc = 0;
    logic        done_ab = 1'b0;
    int          first_acc = -1;

    task automatic drive_src();
        src_valid = feed_en && (src_idx < src_n);
        src_data  = (src_idx < src_n) ? src_words[src_idx] : 16'h0000;
    endtask

    // One clock: log handshakes seen before the edge, then update stimulus after it
    task automatic tick();
        bit sf, wf;
        sf = src_valid && src_ready;
        wf = fl_wvalid && fl_wready;
        if (wf && wn < 32) begin
            wa[wn] = fl_memory_address; wd[wn] = fl_memory_data; wc[wn] = cyc; wn++;
        end
        if (sf) begin
            if (first_acc < 0) first_acc = cyc;
            src_idx++;
        end
        if (done) begin
            done_n++; done_cyc = cyc; done_ab = aborted;
        end
        @(posedge CLK); #1;
        cyc++;
        dma_start = 1'b0;
        dma_abort = 1'b0;
        drive_src();
    endtask

    task automatic load_src(input int n, input logic [15:0] seed);
        for (int i = 0; i < n; i++) src_words[i] = seed + 16'(i) * 16'h1111;
        src_n = n; src_idx = 0; wn = 0; done_n = 0; first_acc = -1; feed_en = 1'b1;
    endtask

    task automatic start(input logic [15:0] base, input logic [15:0] cnt);
        dma_base_addr = base; dma_count = cnt; dma_start = 1'b1;
        drive_src();
        tick();
    endtask

    task automatic wait_done(input int max);
        int d0, k;
        d0 = done_n; k = 0;
        while (done_n == d0 && k < max) begin tick(); k++; end
        total++;
        if (done_n == d0) $display("FAIL done_timeout: no done within %0d cycles", max);
        else passed++;
    endtask

    task automatic test_reset();
        RSTb = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        total++;
        if ({src_ready, fl_wvalid, busy, done, aborted} !== 5'b00000 ||
            fl_memory_address !== 16'h0000 || fl_memory_data !== 16'h0000) begin
            $display("FAIL reset_outputs: got rdy=%b wv=%b busy=%b done=%b ab=%b addr=%h data=%h, want all 0",
                     src_ready, fl_wvalid, busy, done, aborted, fl_memory_address, fl_memory_data);
        end else passed++;
        RSTb = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        fl_wready = 1'b1;
        load_src(3, 16'h1111);
        start(16'h4000, 16'd3);
        wait_done(20);
        total++;
        if (wn !== 3) $display("FAIL basic_count: got %0d writes, want 3", wn);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (wa[i] !== 16'h4000 + 16'(i) || wd[i] !== src_words[i])
                $display("FAIL basic_write%0d: got %h/%h, want %h/%h", i, wa[i], wd[i],
                         16'h4000 + 16'(i), src_words[i]);
            else passed++;
        end
        total++;
        if (wc[1] !== wc[0] + 1 || wc[2] !== wc[0] + 2 || wc[0] !== first_acc + 1)
            $display("FAIL basic_timing: accept %0d writes at %0d %0d %0d, want acc+1..acc+3",
                     first_acc, wc[0], wc[1], wc[2]);
        else passed++;
        total++;
        if (done_cyc !== wc[2] + 1 || done_ab !== 1'b0 || busy !== 1'b0)
            $display("FAIL basic_done: done at %0d ab=%b busy=%b, want %0d ab=0 busy=0",
                     done_cyc, done_ab, busy, wc[2] + 1);
        else passed++;
    endtask

    task automatic test_backpressure();
        fl_wready = 1'b0;
        load_src(6, 16'h0A01);
        start(16'h0100, 16'd6);
        repeat (10) tick();
        total++;
        if (src_idx !== 5 || src_ready !== 1'b0)
            $display("FAIL bp_stall: accepted %0d rdy=%b, want 5 rdy=0", src_idx, src_ready);
        else passed++;
        total++;
        if (fl_wvalid !== 1'b1 || fl_memory_address !== 16'h0100 || fl_memory_data !== 16'h0A01)
            $display("FAIL bp_hold: wv=%b addr=%h data=%h, want 1 0100 0a01",
                     fl_wvalid, fl_memory_address, fl_memory_data);
        else passed++;
        fl_wready = 1'b1;
        wait_done(30);
        total++;
        if (wn !== 6) $display("FAIL bp_count: got %0d writes, want 6", wn);
        else passed++;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (wa[i] !== 16'h0100 + 16'(i) || wd[i] !== src_words[i])
                $display("FAIL bp_write%0d: got %h/%h, want %h/%h", i, wa[i], wd[i],
                         16'h0100 + 16'(i), src_words[i]);
            else passed++;
        end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_a [4];
        exp_a[0] = 16'hFFFE; exp_a[1] = 16'hFFFF; exp_a[2] = 16'h0000; exp_a[3] = 16'h0001;
        fl_wready = 1'b1;
        load_src(4, 16'h0007);
        start(16'hFFFE, 16'd4);
        wait_done(20);
        total++;
        if (wn !== 4) $display("FAIL wrap_count: got %0d writes, want 4", wn);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (wa[i] !== exp_a[i] || wd[i] !== src_words[i])
                $display("FAIL wrap_write%0d: got %h/%h, want %h/%h", i, wa[i], wd[i], exp_a[i], src_words[i]);
            else passed++;
        end
    endtask

    task automatic test_abort();
        int k;
        logic [15:0] ha, hd;
        fl_wready = 1'b1;
        load_src(8, 16'h0123);
        start(16'h2000, 16'd8);
        k = 0;
        while (wn < 2 && k < 20) begin tick(); k++; end
        fl_wready = 1'b0;
        ha = fl_memory_address; hd = fl_memory_data;
        total++;
        if (fl_wvalid !== 1'b1 || ha !== 16'h2002 || hd !== src_words[2])
            $display("FAIL abort_pending: wv=%b addr=%h data=%h, want 1 2002 %h", fl_wvalid, ha, hd, src_words[2]);
        else passed++;
        dma_abort = 1'b1;
        tick();
        repeat (3) begin
            total++;
            if (fl_wvalid !== 1'b1 || fl_memory_address !== ha || fl_memory_data !== hd ||
                src_ready !== 1'b0 || busy !== 1'b1)
                $display("FAIL abort_hold: wv=%b addr=%h data=%h rdy=%b busy=%b, want 1 %h %h 0 1",
                         fl_wvalid, fl_memory_address, fl_memory_data, src_ready, busy, ha, hd);
            else passed++;
            tick();
        end
        fl_wready = 1'b1;
        wait_done(10);
        repeat (3) tick();
        total++;
        if (wn !== 3 || done_ab !== 1'b1 || aborted !== 1'b1 || fl_wvalid !== 1'b0)
            $display("FAIL abort_end: writes=%0d ab_at_done=%b ab=%b wv=%b, want 3 1 1 0",
                     wn, done_ab, aborted, fl_wvalid);
        else passed++;
    endtask

    task automatic test_zero_and_busy_start();
        int wv_seen;
        fl_wready = 1'b1;
        load_src(0, 16'h0000);
        start(16'h1234, 16'd0);
        wv_seen = 0;
        repeat (4) begin
            if (fl_wvalid || busy) wv_seen++;
            tick();
        end
        total++;
        if (done_n !== 1 || wn !== 0 || wv_seen !== 0 || aborted !== 1'b0)
            $display("FAIL zero_count: dones=%0d writes=%0d wv/busy=%0d ab=%b, want 1 0 0 0",
                     done_n, wn, wv_seen, aborted);
        else passed++;
        load_src(2, 16'h0BEE);
        feed_en = 1'b0;
        start(16'h3000, 16'd2);
        tick();
        start(16'h5000, 16'd9);
        feed_en = 1'b1;
        drive_src();
        wait_done(20);
        repeat (2) tick();
        total++;
        if (wn !== 2 || wa[0] !== 16'h3000 || wa[1] !== 16'h3001 || wd[1] !== src_words[1] || src_idx !== 2)
            $display("FAIL busy_start: writes=%0d a0=%h a1=%h d1=%h acc=%0d, want 2 3000 3001 %h 2",
                     wn, wa[0], wa[1], wd[1], src_idx, src_words[1]);
        else passed++;
    endtask

    task automatic test_reset_mid();
        fl_wready = 1'b0;
        load_src(8, 16'h0D00);
        start(16'h7000, 16'd8);
        repeat (4) tick();
        RSTb = 1'b0;
        #1;
        total++;
        if ({src_ready, fl_wvalid, busy, done, aborted} !== 5'b00000 ||
            fl_memory_address !== 16'h0000 || fl_memory_data !== 16'h0000)
            $display("FAIL reset_mid: rdy=%b wv=%b busy=%b done=%b ab=%b addr=%h data=%h, want all 0",
                     src_ready, fl_wvalid, busy, done, aborted, fl_memory_address, fl_memory_data);
        else passed++;
        @(posedge CLK); #1;
        RSTb = 1'b1;
        tick();
        fl_wready = 1'b1;
        load_src(2, 16'h0E01);
        start(16'h6000, 16'd2);
        wait_done(20);
        total++;
        if (wn !== 2 || wa[0] !== 16'h6000 || wd[0] !== 16'h0E01 || wa[1] !== 16'h6001 ||
            wd[1] !== 16'h1F12 || done_ab !== 1'b0)
            $display("FAIL reset_restart: writes=%0d %h/%h %h/%h ab=%b, want 2 6000/0e01 6001/1f12 0",
                     wn, wa[0], wd[0], wa[1], wd[1], done_ab);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_abort();
        test_zero_and_busy_start();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
